// File: rtl/register_scoreboard.sv
// register_scoreboard: per-register in-flight write tracker that raises the ID-stage stall request
// Ports:
//   clk, rst (async, active-low)      clock and reset
//   freeze                            whole pipeline held; no issue or retire counted
//   ID_issue/ID_WB_EN/ID_MEM_R_EN     issuing instruction moves to EXE / writes a reg / is a load
//   ID_Dest                           destination of the issuing instruction
//   WB_WB_EN/WB_Dest                  register-file write retiring this cycle
//   src1/src2/Two_src                 operands of the instruction in ID
//   forward_EN                        forwarding active: stall only on load-use
//   hazard_detected                   stall request toward IF/ID
//   pending_mask                      registers with an outstanding write
//   sb_error                          sticky counter overflow/underflow
module register_scoreboard #(
    parameter int REG_COUNT = 16,
    parameter int ADDR_W    = 4,
    parameter int CNT_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze,
    input  logic                 ID_issue,
    input  logic                 ID_WB_EN,
    input  logic                 ID_MEM_R_EN,
    input  logic [ADDR_W-1:0]    ID_Dest,
    input  logic                 WB_WB_EN,
    input  logic [ADDR_W-1:0]    WB_Dest,
    input  logic [ADDR_W-1:0]    src1,
    input  logic [ADDR_W-1:0]    src2,
    input  logic                 Two_src,
    input  logic                 forward_EN,
    output logic                 hazard_detected,
    output logic [REG_COUNT-1:0] pending_mask,
    output logic                 sb_error
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]     cnt     [REG_COUNT];
    logic [CNT_W-1:0]     cnt_nxt [REG_COUNT];
    logic                 ex_load_valid;
    logic [ADDR_W-1:0]    ex_load_dest;
    logic [REG_COUNT-1:0] busy, iss_hit, ret_hit;
    logic                 issue_acc, retire_acc, err_hit;

    // The register file writes on the falling edge, so a last write retiring
    // this cycle no longer blocks a reader.
    always_comb begin
        for (int r = 0; r < REG_COUNT; r++)
            busy[r] = cnt[r] != '0 && !(WB_WB_EN && WB_Dest == ADDR_W'(r) && cnt[r] == CNT_ONE);
    end

    assign pending_mask    = busy;
    assign hazard_detected = forward_EN
        ? ex_load_valid && (src1 == ex_load_dest || (Two_src && src2 == ex_load_dest))
        : busy[src1] || (Two_src && busy[src2]);
    assign issue_acc  = ID_issue && ID_WB_EN && !freeze && !hazard_detected;
    assign retire_acc = WB_WB_EN && !freeze;

    // Issue and retire on the same register cancel; saturating ends flag an error.
    always_comb begin
        err_hit = 1'b0;
        for (int r = 0; r < REG_COUNT; r++) begin
            iss_hit[r] = issue_acc && ID_Dest == ADDR_W'(r);
            ret_hit[r] = retire_acc && WB_Dest == ADDR_W'(r);
            cnt_nxt[r] = (iss_hit[r] && !ret_hit[r] && cnt[r] != CNT_MAX) ? cnt[r] + CNT_ONE :
                         (ret_hit[r] && !iss_hit[r] && cnt[r] != '0)      ? cnt[r] - CNT_ONE : cnt[r];
            err_hit    = err_hit || (iss_hit[r] && !ret_hit[r] && cnt[r] == CNT_MAX)
                                 || (ret_hit[r] && !iss_hit[r] && cnt[r] == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < REG_COUNT; r++) cnt[r] <= '0;
            ex_load_valid <= 1'b0;
            ex_load_dest  <= '0;
            sb_error      <= 1'b0;
        end else begin
            for (int r = 0; r < REG_COUNT; r++) cnt[r] <= cnt_nxt[r];
            if (!freeze) begin
                ex_load_valid <= issue_acc && ID_MEM_R_EN;
                ex_load_dest  <= ID_Dest;
            end
            sb_error <= sb_error || err_hit;
        end
    end
endmodule

// File: tb/tb_register_scoreboard.sv
// tb_register_scoreboard: directed and random checks of register_scoreboard against a reference model
module tb_register_scoreboard;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze, ID_issue, ID_WB_EN, ID_MEM_R_EN, WB_WB_EN, Two_src, forward_EN;
    logic [3:0]  ID_Dest, WB_Dest, src1, src2;
    logic        hazard_detected, sb_error;
    logic [15:0] pending_mask;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: outstanding-write count per register, load in EXE, error flag.
    int m_cnt [16];
    bit m_lv;
    int m_ld;
    bit m_err;

    always #5 clk = ~clk;

    register_scoreboard dut (
        .clk(clk), .rst(rst), .freeze(freeze), .ID_issue(ID_issue), .ID_WB_EN(ID_WB_EN),
        .ID_MEM_R_EN(ID_MEM_R_EN), .ID_Dest(ID_Dest), .WB_WB_EN(WB_WB_EN), .WB_Dest(WB_Dest),
        .src1(src1), .src2(src2), .Two_src(Two_src), .forward_EN(forward_EN),
        .hazard_detected(hazard_detected), .pending_mask(pending_mask), .sb_error(sb_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_busy(input int r);
        return m_cnt[r] != 0 && !(WB_WB_EN && int'(WB_Dest) == r && m_cnt[r] == 1);
    endfunction

    function automatic bit m_haz();
        if (forward_EN) return m_lv && (int'(src1) == m_ld || (Two_src && int'(src2) == m_ld));
        return m_busy(int'(src1)) || (Two_src && m_busy(int'(src2)));
    endfunction

    task automatic idle();
        freeze = 0; ID_issue = 0; ID_WB_EN = 0; ID_MEM_R_EN = 0; ID_Dest = 0;
        WB_WB_EN = 0; WB_Dest = 0; src1 = 0; src2 = 0; Two_src = 0;
    endtask

    task automatic issue(input int d, input bit load);
        idle();
        ID_issue = 1; ID_WB_EN = 1; ID_MEM_R_EN = load; ID_Dest = 4'(d);
    endtask

    // Compare everything against the model, advance the model, then cross the edge.
    task automatic tick();
        logic [31:0] mask, obs_c, exp_c;
        bit iss, ret;
        @(negedge clk);
        mask = 0; obs_c = 0; exp_c = 0;
        for (int r = 0; r < 16; r++) begin
            mask[r] = m_busy(r);
            if (r < 16) begin
                obs_c[2*r +: 2] = dut.cnt[r];
                exp_c[2*r +: 2] = 2'(m_cnt[r]);
            end
        end
        check("hazard", {31'b0, hazard_detected}, {31'b0, m_haz()});
        check("pending_mask", {16'b0, pending_mask}, mask);
        check("sb_error", {31'b0, sb_error}, {31'b0, m_err});
        check("cnt", obs_c, exp_c);
        if (!freeze) begin
            iss = ID_issue && ID_WB_EN && !m_haz();
            ret = WB_WB_EN;
            if (iss && !(ret && WB_Dest == ID_Dest)) begin
                if (m_cnt[ID_Dest] == 3) m_err = 1; else m_cnt[ID_Dest]++;
            end
            if (ret && !(iss && WB_Dest == ID_Dest)) begin
                if (m_cnt[WB_Dest] == 0) m_err = 1; else m_cnt[WB_Dest]--;
            end
            m_lv = iss && ID_MEM_R_EN;
            m_ld = int'(ID_Dest);
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear immediately.
    task automatic do_reset();
        #2;
        rst = 0;
        #1;
        check("rst_pending", {16'b0, pending_mask}, 0);
        check("rst_hazard", {31'b0, hazard_detected}, 0);
        check("rst_err", {31'b0, sb_error}, 0);
        for (int r = 0; r < 16; r++) m_cnt[r] = 0;
        m_lv = 0; m_ld = 0; m_err = 0;
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    initial begin
        idle();
        forward_EN = 0;
        for (int r = 0; r < 16; r++) m_cnt[r] = 0;
        m_lv = 0; m_ld = 0; m_err = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1;

        // reset mid-stream with cnt[3]=2
        issue(3, 0); tick(); tick();
        idle(); #1;
        check("cnt3_two", {30'b0, dut.cnt[3]}, 2);
        do_reset();

        // RAW chain without forwarding
        issue(2, 0); tick();
        issue(6, 0); src1 = 2; #1;
        check("raw_c1", {31'b0, hazard_detected}, 1); tick();
        check("raw_c2", {31'b0, hazard_detected}, 1); tick();
        WB_WB_EN = 1; WB_Dest = 2; #1;
        check("raw_c3", {31'b0, hazard_detected}, 0); tick();
        idle(); #1;
        check("raw_cnt2", {30'b0, dut.cnt[2]}, 0);
        check("raw_cnt6", {30'b0, dut.cnt[6]}, 1);
        tick();

        // load-use with forwarding
        forward_EN = 1;
        issue(5, 1); tick();
        issue(8, 0); src2 = 5; Two_src = 1; #1;
        check("lu_stall", {31'b0, hazard_detected}, 1); tick();
        check("lu_release", {31'b0, hazard_detected}, 0); tick();
        issue(5, 1); tick();
        issue(8, 0); src2 = 5; Two_src = 0; #1;
        check("lu_one_src", {31'b0, hazard_detected}, 0); tick();

        // freeze
        issue(7, 1); freeze = 1; tick();
        check("frz_cnt7", {30'b0, dut.cnt[7]}, 0);
        check("frz_lv", {31'b0, dut.ex_load_valid}, 0);
        issue(7, 1); tick();
        issue(9, 0); src1 = 7; freeze = 1;
        for (int k = 0; k < 3; k++) begin
            #1; check("frz_hold", {31'b0, hazard_detected}, 1); tick();
        end
        freeze = 0; #1;
        check("frz_after", {31'b0, hazard_detected}, 1); tick();
        check("frz_release", {31'b0, hazard_detected}, 0); tick();

        // simultaneous issue and retire
        forward_EN = 0;
        do_reset();
        issue(4, 0); tick();
        issue(4, 0); WB_WB_EN = 1; WB_Dest = 4; tick();
        check("sim_same", {30'b0, dut.cnt[4]}, 1);
        issue(1, 0); tick();
        issue(4, 0); WB_WB_EN = 1; WB_Dest = 1; tick();
        check("sim_diff4", {30'b0, dut.cnt[4]}, 2);
        check("sim_diff1", {30'b0, dut.cnt[1]}, 0);

        // underflow and overflow
        idle(); WB_WB_EN = 1; WB_Dest = 9; tick();
        check("uf_err", {31'b0, sb_error}, 1);
        check("uf_cnt9", {30'b0, dut.cnt[9]}, 0);
        idle(); tick(); tick();
        check("uf_sticky", {31'b0, sb_error}, 1);
        do_reset();
        for (int k = 0; k < 4; k++) begin issue(10, 0); tick(); end
        check("of_cnt10", {30'b0, dut.cnt[10]}, 3);
        check("of_err", {31'b0, sb_error}, 1);
        do_reset();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            if (i % 200 == 199) do_reset();
            if (i % 50 == 0) forward_EN = 1'($urandom_range(0, 1));
            freeze      = $urandom_range(0, 9) == 0;
            ID_issue    = $urandom_range(0, 9) < 7;
            ID_WB_EN    = $urandom_range(0, 3) != 0;
            ID_MEM_R_EN = $urandom_range(0, 2) == 0;
            ID_Dest     = 4'($urandom_range(0, 7));
            src1        = 4'($urandom_range(0, 7));
            src2        = 4'($urandom_range(0, 7));
            Two_src     = 1'($urandom_range(0, 1));
            WB_WB_EN    = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 7));
            for (int k = 0; k < 8; k++)
                if (m_cnt[(r + k) % 8] != 0) begin r = (r + k) % 8; break; end
            if ($urandom_range(0, 19) == 0) r = int'($urandom_range(0, 15));
            WB_Dest = 4'(r);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/register_scoreboard.md
# register_scoreboard

Sequential replacement for the combinational stall check in the ARM pipeline's ID stage. It records every register write issued out of ID and clears the record when that write retires in WB. It raises `hazard_detected` toward the IF/ID freeze logic whenever the decoding instruction reads a register with an outstanding write. With forwarding enabled, it stalls only on the load-use case, using its own record of a load sitting in EXE.

## Interface
- `REG_COUNT`, default 16: number of architectural registers tracked.
- `ADDR_W`, default 4: register index width.
- `CNT_W`, default 2: per-register in-flight counter width; the maximum count is 2^CNT_W-1.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `freeze` input 1: whole pipeline held this cycle (memory wait); no issue or retire is counted.
- `ID_issue` input 1: the ID-stage instruction moves into EXE at this edge (already excludes flush).
- `ID_WB_EN` input 1: the issuing instruction writes a register.
- `ID_MEM_R_EN` input 1: the issuing instruction is a load.
- `ID_Dest` input ADDR_W: destination of the issuing instruction.
- `WB_WB_EN` input 1: the WB stage writes the register file this cycle.
- `WB_Dest` input ADDR_W: WB destination.
- `src1`, `src2` input ADDR_W: source registers of the instruction in ID.
- `Two_src` input 1: `src2` is a real operand.
- `forward_EN` input 1: the forwarding unit is active.
- `hazard_detected` output 1: stall request for IF/ID; combinational from state and inputs.
- `pending_mask` output REG_COUNT: bit r = register r has at least one outstanding write.
- `sb_error` output 1: sticky counter overflow/underflow flag.

## Operation
- State:
  - `cnt[r]`, CNT_W bits per register.
  - `ex_load_valid` and `ex_load_dest`, which describe the load currently in EXE.
  - `sb_error`.
- Accepted issue: `ID_issue & ID_WB_EN & ~freeze & ~hazard_detected`.
- Accepted retire: `WB_WB_EN & ~freeze`.
- Counter update per register r:
  - Issue hit on r, no retire hit: `cnt[r]+1`.
  - Retire hit on r, no issue hit: `cnt[r]-1`.
  - Issue and retire both hit r: unchanged.
  - Otherwise: unchanged.
- Saturation:
  - An issue hit with `cnt[r]` already at its maximum and no retire hit leaves the count unchanged and sets `sb_error`.
  - A retire hit with `cnt[r]==0` and no issue hit holds the count at 0 and sets `sb_error`.
- Load tracker:
  - When `~freeze`: `ex_load_valid <= accepted issue & ID_MEM_R_EN` and `ex_load_dest <= ID_Dest`.
  - When `freeze`: both are held.
  - A stalled instruction issues nothing, so the next cycle's EXE holds a bubble and `ex_load_valid` becomes 0.
- Effective busy: `busy[r] = (cnt[r]!=0) & ~(WB_WB_EN & WB_Dest==r & cnt[r]==1)`.
  - The register file writes on the falling edge, so a producer retiring this cycle does not stall a reader.
  - `pending_mask = busy`.
- `hazard_detected` when `forward_EN==0`: `busy[src1] | (Two_src & busy[src2])`.
- `hazard_detected` when `forward_EN==1`: `ex_load_valid & (src1==ex_load_dest | (Two_src & src2==ex_load_dest))`.
- `hazard_detected` is not gated by `freeze`. The top level already holds IF/ID under freeze.
- Reset (asynchronous, active-low):
  - All `cnt` = 0, `ex_load_valid` = 0, `ex_load_dest` = 0, `sb_error` = 0.
  - Therefore `hazard_detected` = 0 and `pending_mask` = 0.
  - Reset mid-operation discards all in-flight records. Reset clears the pipeline too, so this is consistent.
- `sb_error` clears only on reset.

## Timing
- Issue to visibility: a write accepted at edge N is reflected in `pending_mask` and `hazard_detected` from cycle N+1. Latency is 1 cycle.
- Retire to release: in the retiring cycle itself, `busy` already drops, because it is combinational on `WB_*`. `cnt` decrements at the end of that cycle.
- Without forwarding, a dependent instruction directly behind its producer stalls for 2 cycles (while the producer is in EXE and MEM) and issues when the producer is in WB.
- With forwarding, a load-use pair stalls exactly 1 cycle; a non-load producer never stalls.
- `freeze` freezes all state; outputs stay combinationally consistent with the held state.

## Test plan
- Reset: assert `rst`=0 mid-stream with `cnt[3]`=2 → immediately `pending_mask`=0, `hazard_detected`=0, `sb_error`=0.
- No forwarding, RAW chain:
  - Issue write R2 at edge 0; the next instruction has `src1`=2, `Two_src`=0.
  - Required: `hazard_detected`=1 in cycles 1 and 2.
  - Cycle 3 (`WB_WB_EN`=1, `WB_Dest`=2): `hazard_detected`=0 and the reader issues.
  - `cnt[2]` returns to 0 after edge 3.
- Forwarding, load-use: issue a load to R5; the next instruction has `src2`=5, `Two_src`=1 → `hazard_detected`=1 for exactly 1 cycle. Repeat with `Two_src`=0 → no stall.
- Freeze:
  - Issue a load to R7 with `freeze`=1 → `cnt[7]` stays 0 and `ex_load_valid` is unchanged.
  - Then hold `freeze`=1 for 3 cycles with the load in EXE → `hazard_detected` stays 1 throughout for a reader of R7.
- Simultaneous events:
  - Issue to R4 while WB retires R4 with `cnt[4]`=1 → `cnt[4]` stays 1.
  - Issue to R4 while WB retires R1 → `cnt[4]`=2 and `cnt[1]` decrements.
- Error: retire R9 with `cnt[9]`=0 → `sb_error`=1, `cnt[9]`=0; the flag stays set until `rst`=0.
